// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard controller for a five-stage (F, D, E, M, W) ARM core.
//
// Purpose:
//   - Operand forwarding selects for the two E-stage source operands.
//   - Load-use and taken-branch stall/flush control.
//   - Multi-cycle data-memory wait sequencing with a timeout watchdog (IDLE/WAIT/ERR).
//   - Saturating performance counter of cycles in which fetch is stalled.
//
// Ports:
//   clk                     system clock, rising edge
//   reset                   asynchronous, active-low reset
//   RA1D, RA2D              decode-stage source register addresses
//   RA1E, RA2E              execute-stage source register addresses
//   WA3E, WA3M, WA3W        destination addresses in E, M, W
//   RegWE, RegWM, RegWW     register-write enables per stage
//   MemtoRegE               E-stage instruction is a load
//   BranchTakenE            branch resolved taken in E
//   MemReqM, MemReadyM      M-stage memory request / completion
//   ForwardAE, ForwardBE    00 = register file, 01 = W result, 10 = M ALU result
//   StallF/D/E/M            hold stage register
//   FlushD/E/W              clear stage register to a bubble
//   MemErr                  sticky memory-timeout error
//   StallCount              saturating count of cycles with StallF=1

module hazard_sequencer #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    RA1D,
    input  logic [3:0]    RA2D,
    input  logic [3:0]    RA1E,
    input  logic [3:0]    RA2E,
    input  logic [3:0]    WA3E,
    input  logic [3:0]    WA3M,
    input  logic [3:0]    WA3W,
    input  logic          RegWE,
    input  logic          RegWM,
    input  logic          RegWW,
    input  logic          MemtoRegE,
    input  logic          BranchTakenE,
    input  logic          MemReqM,
    input  logic          MemReadyM,
    output logic [1:0]    ForwardAE,
    output logic [1:0]    ForwardBE,
    output logic          StallF,
    output logic          StallD,
    output logic          StallE,
    output logic          StallM,
    output logic          FlushD,
    output logic          FlushE,
    output logic          FlushW,
    output logic          MemErr,
    output logic [CW-1:0] StallCount
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int unsigned    WW       = $clog2(TIMEOUT);
    localparam logic [WW-1:0]  WaitLast = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr
    } state_e;

    state_e        state_q;
    logic [WW-1:0] wait_cnt_q;
    logic          mem_err_q;
    logic [CW-1:0] stall_cnt_q;

    logic          mem_stall;
    logic          ld_stall;

    // R15 is the PC and is never forwarded; M result beats W result.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic       we_m,
                                           input logic [3:0] wa_m,
                                           input logic       we_w,
                                           input logic [3:0] wa_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'hF) begin
            if (we_m && (wa_m == ra)) begin
                sel = 2'b10;
            end else if (we_w && (wa_w == ra)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    // Memory stall is a function of the current state and this cycle's handshake, so it
    // drops in the very cycle MemReadyM arrives.
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            StIdle:  mem_stall = MemReqM && !MemReadyM;
            StWait:  mem_stall = !MemReadyM;
            StErr:   mem_stall = 1'b1;
            default: mem_stall = 1'b1;
        endcase
    end

    assign ld_stall = MemtoRegE && RegWE && ((WA3E == RA1D) || (WA3E == RA2D));

    // Priority: memory stall > taken branch > load-use. All outputs are forced low while
    // reset is asserted, independent of the clock.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (reset) begin
            ForwardAE = fwd_sel(RA1E, RegWM, WA3M, RegWW, WA3W);
            ForwardBE = fwd_sel(RA2E, RegWM, WA3M, RegWW, WA3W);
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (ld_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Memory-wait watchdog FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (MemReqM && !MemReadyM) begin
                        state_q    <= StWait;
                        wait_cnt_q <= WW'(1);
                    end
                end
                StWait: begin
                    if (MemReadyM) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WaitLast) begin
                        state_q   <= StErr;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end
                end
                StErr:   state_q <= StErr;
                default: state_q <= StErr;
            endcase
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (StallF && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CW'(1);
        end
    end

    assign MemErr     = mem_err_q;
    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 4;

    logic          clk;
    logic          reset;
    logic [3:0]    RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic          RegWE, RegWM, RegWW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [CW-1:0] StallCount;

    hazard_sequencer #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .RA1D         (RA1D),
        .RA2D         (RA2D),
        .RA1E         (RA1E),
        .RA2E         (RA2E),
        .WA3E         (WA3E),
        .WA3M         (WA3M),
        .WA3W         (WA3W),
        .RegWE        (RegWE),
        .RegWM        (RegWM),
        .RegWW        (RegWW),
        .MemtoRegE    (MemtoRegE),
        .BranchTakenE (BranchTakenE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemErr       (MemErr),
        .StallCount   (StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sf, sd, se, sm, fd, fe, fw, me;
        logic [3:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int          exp_cnt     = 0;
    logic        last_sf     = 1'b0;

    task automatic check(input string tag, input string field,
                         input logic [3:0] got, input logic [3:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, got, want);
        end
    endtask

    // Push the expected outputs for the stimulus just driven, then pop and compare.
    task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                        input logic sf, input logic sd, input logic se, input logic sm,
                        input logic fd, input logic fe, input logic fw, input logic me);
        exp_t e;
        e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sd; e.se = se; e.sm = sm;
        e.fd = fd; e.fe = fe; e.fw = fw; e.me = me; e.cnt = 4'(exp_cnt);
        exp_q.push_back(e);
        last_sf = sf;
        #2;
        e = exp_q.pop_front();
        check(tag, "ForwardAE",  {2'b00, ForwardAE}, {2'b00, e.fa});
        check(tag, "ForwardBE",  {2'b00, ForwardBE}, {2'b00, e.fb});
        check(tag, "StallF",     {3'b000, StallF},   {3'b000, e.sf});
        check(tag, "StallD",     {3'b000, StallD},   {3'b000, e.sd});
        check(tag, "StallE",     {3'b000, StallE},   {3'b000, e.se});
        check(tag, "StallM",     {3'b000, StallM},   {3'b000, e.sm});
        check(tag, "FlushD",     {3'b000, FlushD},   {3'b000, e.fd});
        check(tag, "FlushE",     {3'b000, FlushE},   {3'b000, e.fe});
        check(tag, "FlushW",     {3'b000, FlushW},   {3'b000, e.fw});
        check(tag, "MemErr",     {3'b000, MemErr},   {3'b000, e.me});
        check(tag, "StallCount", StallCount,         e.cnt);
    endtask

    // Advance one clock; the counter model follows the expected StallF of the last step.
    task automatic tick();
        @(posedge clk);
        if (last_sf && reset && exp_cnt < 15) exp_cnt++;
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        RegWE = 1'b0; RegWM = 1'b0; RegWW = 1'b0;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    task automatic set_ldstall_rb();
        MemtoRegE = 1'b1; RegWE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #1;
        // Reset held low: every output forced low even with hazards present.
        RA1E = 4'd3; WA3M = 4'd3; RegWM = 1'b1; MemReqM = 1'b1;
        set_ldstall_rb();
        step("rst_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        step("rst_edge", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        clear_inputs();
        reset = 1'b1;
        step("idle", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Forwarding
        RA1E = 4'd3; RA2E = 4'd3; WA3M = 4'd3; RegWM = 1'b1; WA3W = 4'd3; RegWW = 1'b1;
        step("fwd_m_prio", 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
        RegWM = 1'b0;
        step("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        RA1E = 4'd15; WA3M = 4'd15; WA3W = 4'd15; RegWM = 1'b1;
        step("fwd_r15", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        RA2E = 4'd4; WA3M = 4'd9; WA3W = 4'd4;
        step("fwd_b_w", 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clear_inputs();

        // Load-use, one cycle only
        set_ldstall_rb();
        step("ldstall_rb", 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        clear_inputs();
        step("ldstall_off", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        MemtoRegE = 1'b1; RegWE = 1'b1; WA3E = 4'd7; RA1D = 4'd7;
        step("ldstall_ra", 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        RegWE = 1'b0;
        step("ldstall_nowe", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clear_inputs();

        // Branch beats load-use
        set_ldstall_rb();
        BranchTakenE = 1'b1;
        step("br_ld", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        clear_inputs();

        // Memory wait: three unready cycles, branch and load-use suppressed
        MemReqM = 1'b1; BranchTakenE = 1'b1;
        set_ldstall_rb();
        for (int i = 0; i < 3; i++) begin
            step("mem_wait", 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0);
            tick();
        end
        clear_inputs();
        MemReqM = 1'b1; MemReadyM = 1'b1; BranchTakenE = 1'b1;
        step("mem_ready", 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
        tick();
        BranchTakenE = 1'b0;
        step("mem_zero_wait", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clear_inputs();

        // Saturation: load-use held for 20 cycles
        set_ldstall_rb();
        for (int i = 0; i < 20; i++) begin
            step("sat", 2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0);
            tick();
        end
        clear_inputs();
        step("sat_hold", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Timeout: four stall cycles, then sticky ERR
        MemReqM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step("to_wait", 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 0);
            tick();
        end
        step("to_err", 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1);
        tick();
        MemReadyM = 1'b1;
        step("err_ready", 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1);
        tick();
        MemReqM = 1'b0;
        BranchTakenE = 1'b1;
        step("err_noreq", 2'b00, 2'b00, 1, 1, 1, 1, 0, 0, 1, 1);
        tick();

        // Asynchronous reset clears everything without a clock edge
        reset = 1'b0;
        exp_cnt = 0;
        step("async_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        clear_inputs();
        reset = 1'b1;
        step("post_rst", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        MemReqM = 1'b1; MemReadyM = 1'b1;
        step("post_rst_mem", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
